blackbox_monitor: RTL

- Multi-channel, registered successor to the single-bit Lab 1 black-box evaluator.
- Each channel computes x = ~u | a | ~e, which is equivalent to x = ~(u & e & ~a).
- Each channel counts consecutive cycles in which that condition is violated and raises a sticky alarm after THRESHOLD consecutive violations.
- Pending alarms are reported one at a time, lowest channel first, over a valid/ack interrupt handshake to the lab's top-level controller.

---
 rtl/blackbox_monitor_if.sv | 26 ++
 rtl/blackbox_monitor.sv | 66 ++++++
 2 files changed

// File: rtl/blackbox_monitor_if.sv
// blackbox_monitor_if: channel inputs, status outputs and irq valid/ack handshake of blackbox_monitor
interface blackbox_monitor_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 4,
  parameter int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic enable;
  logic [CHANNELS-1:0] e;
  logic [CHANNELS-1:0] u;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] x;
  logic [CHANNELS*CNT_W-1:0] viol_count;
  logic [CHANNELS-1:0] alarm;
  logic irq_valid;
  logic [IDX_W-1:0] irq_chan;
  logic irq_ack;
  modport master (
    output enable, e, u, a, clear, irq_ack,
    input x, viol_count, alarm, irq_valid, irq_chan
  );
  modport slave (
    input enable, e, u, a, clear, irq_ack,
    output x, viol_count, alarm, irq_valid, irq_chan
  );
endinterface

// File: rtl/blackbox_monitor.sv
// blackbox_monitor: per-channel violation run counters with sticky alarms reported lowest-first (ports: clk, reset, bus.slave)
module blackbox_monitor #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 4,
  parameter int THRESHOLD = 3,
  parameter int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic clk,
  input logic reset,
  blackbox_monitor_if.slave bus
);
  if (THRESHOLD < 1 || THRESHOLD > (2**CNT_W) - 1) begin : g_bad_threshold
    $error("THRESHOLD out of range for CNT_W");
  end
  logic [CHANNELS-1:0] x_q, x_d, alarm_q, alarm_d, pend_q, pend_d, viol;
  logic [CHANNELS*CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] irq_chan;
  logic [CNT_W-1:0] nxt;
  assign viol = bus.u & bus.e & ~bus.a;
  always_comb begin
    irq_chan = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) irq_chan = pend_q[i] ? IDX_W'(i) : irq_chan;
  end
  always_comb begin
    x_d = x_q;
    cnt_d = cnt_q;
    alarm_d = alarm_q;
    pend_d = pend_q;
    nxt = '0;
    if ((|pend_q) && bus.irq_ack) pend_d[irq_chan] = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      x_d[i] = bus.enable ? ~viol[i] : x_q[i];
      nxt = !viol[i] ? '0 : (&cnt_q[i*CNT_W +: CNT_W]) ? cnt_q[i*CNT_W +: CNT_W] : cnt_q[i*CNT_W +: CNT_W] + 1'b1;
      if (bus.clear[i]) begin
        cnt_d[i*CNT_W +: CNT_W] = '0;
        alarm_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end else if (bus.enable) begin
        cnt_d[i*CNT_W +: CNT_W] = nxt;
        // only the 0->1 alarm transition queues a report
        if (viol[i] && nxt == CNT_W'(THRESHOLD) && !alarm_q[i]) begin
          alarm_d[i] = 1'b1;
          pend_d[i] = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '1;
      cnt_q <= '0;
      alarm_q <= '0;
      pend_q <= '0;
    end else begin
      x_q <= x_d;
      cnt_q <= cnt_d;
      alarm_q <= alarm_d;
      pend_q <= pend_d;
    end
  end
  assign bus.x = x_q;
  assign bus.viol_count = cnt_q;
  assign bus.alarm = alarm_q;
  assign bus.irq_valid = |pend_q;
  assign bus.irq_chan = irq_chan;
endmodule
